spi_master_ctrl: RTL

//  Initiator end of the team's SPI link: accepts 2-bit command + 8-bit payload words from a host,

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_shift_unit.sv | 58 +++++
 rtl/spi_master_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared command codes, FSM state encoding and frame geometry for the SPI initiator.
package spi_pkg;

    localparam int FRAME_W = 10;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SHIFT,
        ST_TURN,
        ST_READ,
        ST_GAP
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_shift_unit.sv
// Serial datapath: parallel-load PISO drives MOSI MSB first, SIPO collects MISO MSB first,
// plus a down-counter that holds at zero. No flow control; the controller sequences every enable.
module spi_shift_unit #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              shift_i,
    input  logic              sample_i,
    input  logic              miso_i,
    input  logic              cnt_load_i,
    input  logic [CNT_W-1:0]  cnt_val_i,
    output logic              mosi_o,
    output logic [DATA_W-1:0] rx_o,
    output logic              cnt_zero_o
);

    logic [WORD_W-1:0] piso_q, piso_d;
    logic [DATA_W-1:0] sipo_q, sipo_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    always_comb begin
        piso_d = piso_q;
        sipo_d = sipo_q;
        cnt_d  = cnt_q;
        if (load_i)
            piso_d = word_i;
        else if (shift_i)
            piso_d = {piso_q[WORD_W-2:0], 1'b0};
        if (sample_i)
            sipo_d = {sipo_q[DATA_W-2:0], miso_i};
        if (cnt_load_i)
            cnt_d = cnt_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            piso_q <= '0;
            sipo_q <= '0;
            cnt_q  <= '0;
        end else begin
            piso_q <= piso_d;
            sipo_q <= sipo_d;
            cnt_q  <= cnt_d;
        end
    end

    assign mosi_o     = piso_q[WORD_W-1];
    assign rx_o       = sipo_q;
    assign cnt_zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: one host command per frame, reply returned 1 cycle after GAP; cmd_ready only in IDLE, no queueing.
// SPI_PROTO_CHECK_EN: refuse rd-data (pulse cmd_err, no frame) until an rd-addr has been sent.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TA_CYCLES  = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              cmd_err,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int WORD_W = 2 + DATA_W;
    // GAP is included so a long inter-frame gap still fits the shared counter.
    localparam int CNT_W  = $clog2(max4(WORD_W, DATA_W, TA_CYCLES, GAP_CYCLES) + 1);

    state_t            state_q, state_d;
    logic              ready_q;
    logic              rd_q, rd_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;

    logic              accept, blocked, is_rd;
    logic [WORD_W-1:0] word;
    logic              load, shift_en, sample_en, cnt_load, cnt_zero, mosi_bit;
    logic [CNT_W-1:0]  cnt_val;
    logic [DATA_W-1:0] rx;

    assign accept = cmd_valid & cmd_ready;
    assign is_rd  = (cmd_type == CMD_RD_DATA);
    assign word   = {cmd_type, is_rd ? {DATA_W{1'b0}} : cmd_data};

`ifdef SPI_PROTO_CHECK_EN
    logic addr_loaded_q;

    assign blocked = is_rd & ~addr_loaded_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_loaded_q <= 1'b0;
        else if (accept && cmd_type == CMD_RD_ADDR)
            addr_loaded_q <= 1'b1;
    end
`else
    assign blocked = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_d      = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        sample_en  = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (blocked) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_SELECT;
                        load    = 1'b1;
                        rd_d    = is_rd;
                    end
                end
            end
            ST_SELECT: begin
                state_d  = ST_SHIFT;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(WORD_W - 1);
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (!rd_q) begin
                        state_d = ST_GAP;
                        cnt_val = CNT_W'(GAP_CYCLES - 1);
                    end else if (TA_CYCLES > 0) begin
                        state_d = ST_TURN;
                        cnt_val = CNT_W'(TA_CYCLES - 1);
                    end else begin
                        state_d = ST_READ;
                        cnt_val = CNT_W'(DATA_W - 1);
                    end
                end
            end
            ST_TURN: begin
                if (cnt_zero) begin
                    state_d  = ST_READ;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DATA_W - 1);
                end
            end
            ST_READ: begin
                sample_en = 1'b1;
                if (cnt_zero) begin
                    state_d  = ST_GAP;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(GAP_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = rd_q;
                    if (rd_q)
                        rd_data_d = rx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            rd_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    spi_shift_unit #(
        .WORD_W (WORD_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .word_i     (word),
        .shift_i    (shift_en),
        .sample_i   (sample_en),
        .miso_i     (MISO),
        .cnt_load_i (cnt_load),
        .cnt_val_i  (cnt_val),
        .mosi_o     (mosi_bit),
        .rx_o       (rx),
        .cnt_zero_o (cnt_zero)
    );

    // SS_n and MOSI decode straight from state so an async reset releases the bus at once.
    assign SS_n      = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign MOSI      = ((state_q == ST_SELECT) || (state_q == ST_SHIFT)) ? mosi_bit : 1'b0;
    assign cmd_ready = ready_q && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign cmd_err   = err_q;

endmodule
